// File: rtl/cyclic_lamp_pkg.sv
// rtl/cyclic_lamp_pkg.sv - shared encodings for the cyclic lamp monitor
// States, colour codes, lamp words, error causes and colour ordering helpers.
package cyclic_lamp_pkg;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_RED    = 3'd1,
      ST_GREEN  = 3'd2,
      ST_YELLOW = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      COL_NONE = 2'd0,
      COL_R    = 2'd1,
      COL_G    = 2'd2,
      COL_Y    = 2'd3
   } colour_e;

   localparam logic [0:2] LIGHT_R = 3'b100;
   localparam logic [0:2] LIGHT_G = 3'b010;
   localparam logic [0:2] LIGHT_Y = 3'b001;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_ONEHOT = 2'd1;
   localparam logic [1:0] ERR_ORDER  = 2'd2;
   localparam logic [1:0] ERR_DWELL  = 2'd3;

   localparam int DWELL_W = 4;

   function automatic colour_e next_colour(input colour_e c);
      case (c)
         COL_R:   return COL_G;
         COL_G:   return COL_Y;
         COL_Y:   return COL_R;
         default: return COL_NONE;
      endcase
   endfunction

   function automatic state_e colour_state(input colour_e c);
      case (c)
         COL_R:   return ST_RED;
         COL_G:   return ST_GREEN;
         COL_Y:   return ST_YELLOW;
         default: return ST_SYNC;
      endcase
   endfunction

   function automatic colour_e state_colour(input state_e s);
      case (s)
         ST_RED:    return COL_R;
         ST_GREEN:  return COL_G;
         ST_YELLOW: return COL_Y;
         default:   return COL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cyclic_lamp_monitor_if.sv
// rtl/cyclic_lamp_monitor_if.sv - lamp observation and monitor status bundle
// master drives the lamp word, slave is the monitor reporting status.
interface cyclic_lamp_monitor_if;
   logic [0:2] light;
   logic [1:0] phase;
   logic       locked;
   logic       err;
   logic [1:0] err_code;
   logic [7:0] cycle_cnt;

   modport master (
      output light,
      input  phase, locked, err, err_code, cycle_cnt
   );

   modport slave (
      input  light,
      output phase, locked, err, err_code, cycle_cnt
   );
endinterface

// File: rtl/lamp_decode.sv
// rtl/lamp_decode.sv - lamp word to {onehot_ok, colour} decoder
// Any word that is not exactly one lamp lit decodes to COL_NONE with onehot_ok low.
module lamp_decode
   import cyclic_lamp_pkg::*;
(
   input  logic [0:2] light,
   output logic       onehot_ok,
   output colour_e    colour
);

   always_comb begin
      onehot_ok = 1'b1;
      colour    = COL_NONE;
      case (light)
         LIGHT_R: colour = COL_R;
         LIGHT_G: colour = COL_G;
         LIGHT_Y: colour = COL_Y;
         default: onehot_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/cyclic_lamp_monitor.sv
// rtl/cyclic_lamp_monitor.sv - tracks an R-G-Y lamp cycle and flags the first violation
// Dwell counter and tracking FSM; all status outputs are registered.
module cyclic_lamp_monitor
   import cyclic_lamp_pkg::*;
#(
   parameter int DWELL = 1
)(
   input  logic                 clk,
   input  logic                 rst,
   cyclic_lamp_monitor_if.slave lamp
);

   localparam logic [DWELL_W-1:0] DWELL_L = DWELL_W'(DWELL);

   logic    onehot_ok;
   colour_e colour;
   colour_e cur_colour;

   state_e             state_q, state_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               first_q, first_d;
   logic [1:0]         phase_q, phase_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [7:0]         cycle_cnt_q, cycle_cnt_d;
   logic               fault;
   logic [1:0]         fault_code;

   lamp_decode u_decode (
      .light     (lamp.light),
      .onehot_ok (onehot_ok),
      .colour    (colour)
   );

   assign cur_colour = state_colour(state_q);

   always_comb begin
      state_d     = state_q;
      dwell_d     = dwell_q;
      first_d     = first_q;
      locked_d    = locked_q;
      err_d       = err_q;
      err_code_d  = err_code_q;
      cycle_cnt_d = cycle_cnt_q;
      fault       = 1'b0;
      fault_code  = ERR_NONE;

      case (state_q)
         ST_SYNC: begin
            if (onehot_ok) begin
               state_d = colour_state(colour);
               dwell_d = DWELL_W'(1);
               first_d = 1'b1;
            end
         end
         ST_RED, ST_GREEN, ST_YELLOW: begin
            if (!onehot_ok) begin
               fault      = 1'b1;
               fault_code = ERR_ONEHOT;
            end else if (colour == cur_colour) begin
               if (dwell_q < DWELL_L) begin
                  dwell_d = dwell_q + DWELL_W'(1);
               end else begin
                  fault      = 1'b1;
                  fault_code = ERR_DWELL;
               end
            end else if (colour == next_colour(cur_colour)) begin
               // The first observed colour may be partial, so its length is not judged.
               if (dwell_q == DWELL_L || first_q) begin
                  state_d  = colour_state(colour);
                  dwell_d  = DWELL_W'(1);
                  first_d  = 1'b0;
                  locked_d = 1'b1;
                  if (cur_colour == COL_Y && cycle_cnt_q != 8'hFF) begin
                     cycle_cnt_d = cycle_cnt_q + 8'd1;
                  end
               end else begin
                  fault      = 1'b1;
                  fault_code = ERR_DWELL;
               end
            end else begin
               fault      = 1'b1;
               fault_code = ERR_ORDER;
            end
         end
         default: ;
      endcase

      if (fault) begin
         state_d    = ST_ERROR;
         first_d    = 1'b0;
         locked_d   = 1'b0;
         err_d      = 1'b1;
         err_code_d = fault_code;
      end

      phase_d = state_colour(state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SYNC;
         dwell_q     <= '0;
         first_q     <= 1'b0;
         phase_q     <= 2'd0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         cycle_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         dwell_q     <= dwell_d;
         first_q     <= first_d;
         phase_q     <= phase_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign lamp.phase     = phase_q;
   assign lamp.locked    = locked_q;
   assign lamp.err       = err_q;
   assign lamp.err_code  = err_code_q;
   assign lamp.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cyclic_lamp_monitor.sv
// tb/tb_cyclic_lamp_monitor.sv - bench for cyclic_lamp_monitor at DWELL 1, 2 and 3
// All three instances see the same lamp word and reset; each has its own reference model.
module tb_cyclic_lamp_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [0:2] light = 3'b000;

   always #5 clk = ~clk;

   cyclic_lamp_monitor_if if1 ();
   cyclic_lamp_monitor_if if2 ();
   cyclic_lamp_monitor_if if3 ();

   assign if1.light = light;
   assign if2.light = light;
   assign if3.light = light;

   cyclic_lamp_monitor #(.DWELL(1)) u_dw1 (.clk(clk), .rst(rst), .lamp(if1));
   cyclic_lamp_monitor #(.DWELL(2)) u_dw2 (.clk(clk), .rst(rst), .lamp(if2));
   cyclic_lamp_monitor #(.DWELL(3)) u_dw3 (.clk(clk), .rst(rst), .lamp(if3));

   logic [1:0] o_phase[3];
   logic       o_locked[3];
   logic       o_err[3];
   logic [1:0] o_code[3];
   logic [7:0] o_cycle[3];

   assign o_phase[0] = if1.phase;     assign o_phase[1] = if2.phase;     assign o_phase[2] = if3.phase;
   assign o_locked[0] = if1.locked;   assign o_locked[1] = if2.locked;   assign o_locked[2] = if3.locked;
   assign o_err[0] = if1.err;         assign o_err[1] = if2.err;         assign o_err[2] = if3.err;
   assign o_code[0] = if1.err_code;   assign o_code[1] = if2.err_code;   assign o_code[2] = if3.err_code;
   assign o_cycle[0] = if1.cycle_cnt; assign o_cycle[1] = if2.cycle_cnt; assign o_cycle[2] = if3.cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: colour index 0=none,1=R,2=G,3=Y; run = samples of current colour seen.
   int m_col[3];
   int m_run[3];
   int m_cycles[3];
   int m_code[3];
   bit m_first[3];
   bit m_locked[3];
   bit m_err[3];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [0:2] cw(input int c);
      case (c)
         1:       return 3'b100;
         2:       return 3'b010;
         3:       return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_fail(input int i, input int code);
      m_err[i]    = 1'b1;
      m_code[i]   = code;
      m_col[i]    = 0;
      m_locked[i] = 1'b0;
   endtask

   task automatic model_step(input bit r, input logic [0:2] l);
      int lit;
      int c;
      lit = $countones(l);
      c   = (l == 3'b100) ? 1 : (l == 3'b010) ? 2 : (l == 3'b001) ? 3 : 0;
      for (int i = 0; i < 3; i++) begin
         int dw;
         dw = i + 1;
         if (r) begin
            m_col[i] = 0; m_run[i] = 0; m_cycles[i] = 0; m_code[i] = 0;
            m_first[i] = 1'b0; m_locked[i] = 1'b0; m_err[i] = 1'b0;
         end else if (m_err[i]) begin
            // frozen until reset
         end else if (m_col[i] == 0) begin
            if (lit == 1) begin
               m_col[i] = c; m_run[i] = 1; m_first[i] = 1'b1;
            end
         end else if (lit != 1) begin
            model_fail(i, 1);
         end else if (c == m_col[i]) begin
            if (m_run[i] < dw) m_run[i]++;
            else model_fail(i, 3);
         end else if (c == (m_col[i] % 3) + 1) begin
            if (m_run[i] == dw || m_first[i]) begin
               if (m_col[i] == 3 && m_cycles[i] < 255) m_cycles[i]++;
               m_col[i] = c; m_run[i] = 1; m_first[i] = 1'b0; m_locked[i] = 1'b1;
            end else begin
               model_fail(i, 3);
            end
         end else begin
            model_fail(i, 2);
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dw%0d_phase", i + 1),  int'(o_phase[i]),  m_col[i]);
         check($sformatf("dw%0d_locked", i + 1), int'(o_locked[i]), int'(m_locked[i]));
         check($sformatf("dw%0d_err", i + 1),    int'(o_err[i]),    int'(m_err[i]));
         check($sformatf("dw%0d_code", i + 1),   int'(o_code[i]),   m_code[i]);
         check($sformatf("dw%0d_cycle", i + 1),  int'(o_cycle[i]),  m_cycles[i]);
      end
   endtask

   task automatic step(input bit r, input logic [0:2] l);
      rst   = r;
      light = l;
      @(posedge clk);
      model_step(r, l);
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int n);
      repeat (n) step(1'b1, 3'($urandom_range(0, 7)));
   endtask

   task automatic legal_run(input int dw, input int start, input int nsamples);
      int c;
      int n;
      c = start;
      n = 0;
      for (int k = 0; k < nsamples; k++) begin
         if (n == dw) begin
            c = (c % 3) + 1;
            n = 0;
         end
         step(1'b0, cw(c));
         n++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_dw%0d_phase", tag, i + 1),  int'(o_phase[i]),  0);
         check($sformatf("%s_dw%0d_locked", tag, i + 1), int'(o_locked[i]), 0);
         check($sformatf("%s_dw%0d_err", tag, i + 1),    int'(o_err[i]),    0);
         check($sformatf("%s_dw%0d_code", tag, i + 1),   int'(o_code[i]),   0);
         check($sformatf("%s_dw%0d_cycle", tag, i + 1),  int'(o_cycle[i]),  0);
      end
   endtask

   initial begin
      int tc;
      int tn;
      int td;

      do_reset(2);
      check_all_zero("reset");

      // DWELL=1 clean sequence
      legal_run(1, 1, 1);
      check("dw1_locked_first", int'(o_locked[0]), 0);
      legal_run(1, 2, 1);
      check("dw1_locked_second", int'(o_locked[0]), 1);
      legal_run(1, 3, 8);
      check("dw1_cycle_4th_r", int'(o_cycle[0]), 3);
      check("dw1_err_clean", int'(o_err[0]), 0);
      legal_run(1, 2, 2);

      // DWELL=3 clean cycle then early change
      do_reset(1);
      legal_run(3, 1, 10);
      check("dw3_cycle_one", int'(o_cycle[2]), 1);
      check("dw3_err_clean", int'(o_err[2]), 0);
      step(1'b0, cw(2));
      step(1'b0, cw(2));
      step(1'b0, cw(3));
      check("dw3_err_dwell", int'(o_err[2]), 1);
      check("dw3_code_dwell", int'(o_code[2]), 3);

      // wrong order, then error held under legal input
      do_reset(1);
      legal_run(1, 1, 4);
      step(1'b0, cw(3));
      check("dw1_code_order", int'(o_code[0]), 2);
      check("dw1_phase_err", int'(o_phase[0]), 0);
      legal_run(1, 2, 10);
      check("dw1_err_held", int'(o_err[0]), 1);
      check("dw1_code_held", int'(o_code[0]), 2);
      check("dw1_locked_held", int'(o_locked[0]), 0);
      check("dw1_cycle_frozen", int'(o_cycle[0]), 1);

      // non one-hot while locked, then dark lamps in SYNC
      do_reset(1);
      legal_run(1, 1, 2);
      step(1'b0, 3'b110);
      check("dw1_code_onehot", int'(o_code[0]), 1);
      do_reset(1);
      repeat (3) step(1'b0, 3'b000);
      check_all_zero("sync_dark");

      // DWELL=2 entering mid-green
      do_reset(1);
      step(1'b0, cw(2));
      step(1'b0, cw(3));
      step(1'b0, cw(3));
      check("dw2_partial_err", int'(o_err[1]), 0);
      check("dw2_partial_phase", int'(o_phase[1]), 3);

      // saturation of the cycle counter at each dwell
      for (int dw = 1; dw <= 3; dw++) begin
         do_reset(1);
         legal_run(dw, 1, 3 * dw * 300 + 1);
         check($sformatf("dw%0d_saturate", dw), int'(o_cycle[dw - 1]), 255);
         check($sformatf("dw%0d_sat_err", dw), int'(o_err[dw - 1]), 0);
      end

      // reset mid-dwell and from ERROR
      do_reset(1);
      legal_run(3, 1, 2);
      step(1'b1, cw(1));
      check_all_zero("rst_mid_dwell");
      legal_run(3, 1, 4);
      check("dw3_resume_locked", int'(o_locked[2]), 1);
      check("dw3_resume_phase", int'(o_phase[2]), 2);
      step(1'b0, 3'b111);
      check("dw3_err_before_rst", int'(o_err[2]), 1);
      step(1'b1, 3'b111);
      check_all_zero("rst_in_error");

      // randomized traffic: mostly legal cycles at a random dwell, with glitches and resets
      do_reset(1);
      tc = 1;
      tn = 0;
      td = $urandom_range(1, 3);
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) < 2) begin
            td = $urandom_range(1, 3);
            tc = 1;
            tn = 0;
            step(1'b1, 3'($urandom_range(0, 7)));
         end else if ($urandom_range(0, 99) < 8) begin
            step(1'b0, 3'($urandom_range(0, 7)));
         end else begin
            if (tn >= td) begin
               tc = (tc % 3) + 1;
               tn = 0;
            end
            tn++;
            step(1'b0, cw(tc));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cyclic_lamp_monitor.md
CYCLIC_LAMP_MONITOR -- requirements
Module: cyclic_lamp_monitor

Interface
REQ-001 The block SHALL take parameter DWELL, default 1: the required number of clocks each colour is held, legal range 1..15.
REQ-002 Port clk  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-003 Port rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port light  input  [0:2]  is the observed lamp word, one-hot: bit0=R, bit1=G, bit2=Y.
REQ-005 Port phase  output  2  is the tracked colour: 0=none, 1=R, 2=G, 3=Y.
REQ-006 Port locked  output  1  SHALL be high while the sequence is tracked legally.
REQ-007 Port err  output  1  is the sticky error flag.
REQ-008 Port err_code  output  2  is the error cause: 0=none, 1=not one-hot, 2=wrong order, 3=dwell violation.
REQ-009 Port cycle_cnt  output  8  is the count of completed R-G-Y cycles, saturating.

Function
REQ-010 The FSM SHALL have states SYNC, RED, GREEN, YELLOW and ERROR, with legal order RED->GREEN->YELLOW->RED.
REQ-011 All outputs SHALL be registered, reflecting a light sample one clock after it is sampled.
REQ-012 In SYNC, a one-hot sample SHALL enter the matching colour state with dwell count d=1 and set the first-colour flag; a non-one-hot sample SHALL keep SYNC with no error.
REQ-013 In a colour state, light equal to the current colour SHALL increment d if d<DWELL, else enter ERROR with code 3 (held too long).
REQ-014 In a colour state, light equal to the next colour SHALL advance the state and set d=1 if d==DWELL or the first-colour flag is set, else enter ERROR with code 3 (early change).
REQ-015 The first legal advance SHALL clear the first-colour flag and set locked.
REQ-016 In a colour state, a one-hot light that is neither the current nor the next colour SHALL enter ERROR with code 2.
REQ-017 In a colour state, a non-one-hot light (000, or two or more bits set) SHALL enter ERROR with code 1.
REQ-018 cycle_cnt SHALL increment on each legal YELLOW->RED advance and hold at 255 (no wrap).
REQ-019 ERROR SHALL be absorbing until rst, with err=1, locked=0, phase=0, err_code and cycle_cnt frozen.
REQ-020 Only the first error SHALL be recorded, so err_code never changes while in ERROR.
REQ-021 phase SHALL equal the colour state, and 0 in SYNC and ERROR.

Reset
REQ-022 rst high SHALL force state=SYNC, d=0, first-colour flag=0, phase=0, locked=0, err=0, err_code=0 and cycle_cnt=0 on the next edge.
REQ-023 rst SHALL take priority over every transition, including mid-dwell and in ERROR.
REQ-024 light SHALL be ignored on any clock where rst is high.

Structure
REQ-025 Package cyclic_lamp_pkg SHALL hold the state encoding, the colour constants (R=100, G=010, Y=001 in [0:2] order) and the err_code constants.
REQ-026 One combinational sub-module, lamp_decode, SHALL map light to {onehot_ok, colour[1:0]}.
REQ-027 The dwell counter and FSM SHALL remain in cyclic_lamp_monitor.

Verification
REQ-028 Run DWELL=1: rst 2 clks, then light R,G,Y repeated 4 times -> locked=1 from the second sample's response, err=0, cycle_cnt=3 after the 4th R.
REQ-029 Run DWELL=3: R×3,G×3,Y×3,R -> cycle_cnt=1, err=0; then G×2 followed by Y -> err=1, err_code=3.
REQ-030 Run DWELL=1 locked, then R followed by Y -> err=1, err_code=2, phase=0, locked=0, held for 10 further clocks of legal input.
REQ-031 Run locked, then light=110 -> err_code=1; then light=000 in SYNC after rst -> stays SYNC, err=0.
REQ-032 Run DWELL=2: enter at G×1 (first colour) then Y×2 -> no error; separately run 300 legal cycles -> cycle_cnt saturates at 255.
REQ-033 Assert rst mid-dwell and while in ERROR -> all outputs 0 next clock, and normal tracking resumes from SYNC.
